// File: rtl/umem_pkg.sv
// Shared types and default widths for the unified-memory responder.
package umem_pkg;

    localparam int unsigned ADDR_W_DEF = 14;
    localparam int unsigned LINE_W_DEF = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/umem_array.sv
// Single-port line storage: synchronous write, registered read that holds its
// value until the next read.
module umem_array
    import umem_pkg::*;
#(
    parameter int LINE_W     = LINE_W_DEF,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [LINE_W-1:0]     wdata,
    output logic [LINE_W-1:0]     rdata
);

    logic [LINE_W-1:0] mem [2**DEPTH_LOG2];

    // NOTE: the storage array has no reset; only the read register does, so
    // contents survive rst_n and the array maps onto RAM macros.
    always_ff @(posedge clk) begin
        if (wr_en) mem[idx] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rdata <= '0;
        else if (rd_en) rdata <= mem[idx];
    end

endmodule

// File: rtl/unified_mem_resp.sv
// Unified-memory responder: captures one line request, waits LATENCY cycles,
// pulses rdy. Define UMEM_PROTOCOL_CHECK_EN to add the sticky err output.
module unified_mem_resp
    import umem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int LINE_W     = LINE_W_DEF,
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              re,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata,
    output logic              rdy,
    output logic              busy
`ifdef UMEM_PROTOCOL_CHECK_EN
    ,
    output logic              err
`endif
);

    localparam int CNT_W = 4;
    localparam bit FAST  = (LATENCY == 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    op_t               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;

    logic              req, capture, access;
    op_t               req_op, acc_op;
    logic [ADDR_W-1:0] acc_addr;
    logic [LINE_W-1:0] acc_wdata;

    assign req     = re | we;
    assign req_op  = we ? OP_WR : OP_RD;   // write wins when both are raised
    assign capture = (state == IDLE) && req;

    // With LATENCY=1 the access happens on the capture edge straight from the inputs.
    assign access    = ((state == WAIT) && (cnt == '0)) || (capture && FAST);
    assign acc_op    = (state == IDLE) ? req_op : op_q;
    assign acc_addr  = (state == IDLE) ? addr   : addr_q;
    assign acc_wdata = (state == IDLE) ? wdata  : wdata_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: state_nxt gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (req) state_nxt = FAST ? DONE : WAIT;
            WAIT:    if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rdy  = (state == DONE);
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         cnt <= '0;
        else if (capture)                   cnt <= CNT_W'(LATENCY - 1);
        else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            op_q    <= req_op;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    umem_array #(
        .LINE_W     (LINE_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (access && (acc_op == OP_WR)),
        .rd_en (access && (acc_op == OP_RD)),
        .idx   (acc_addr[DEPTH_LOG2-1:0]),
        .wdata (acc_wdata),
        .rdata (rdata)
    );

`ifdef UMEM_PROTOCOL_CHECK_EN
    logic viol;

    // Requester must hold its strobe and address steady until rdy.
    assign viol = (capture && re && we) ||
                  ((state == WAIT) && ((op_q == OP_WR) ? !we : !re)) ||
                  ((state == WAIT) && (addr != addr_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    err <= 1'b0;
        else if (viol) err <= 1'b1;
    end

    always @(posedge clk) begin
        if (rst_n) assert (!viol) else $error("umem protocol violation addr=%h", addr);
    end
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^{addr[ADDR_W-1:DEPTH_LOG2], addr_q[ADDR_W-1:DEPTH_LOG2]};
`endif

endmodule

// File: tb/tb_unified_mem_resp.sv
// Randomized self-checking bench for unified_mem_resp against a line-array model.
module tb_unified_mem_resp;

    localparam int LAT    = 4;
    localparam int ADDR_W = 14;
    localparam int LINE_W = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              re = 1'b0;
    logic              we = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [LINE_W-1:0] wdata = '0;
    logic [LINE_W-1:0] rdata;
    logic              rdy;
    logic              busy;
`ifdef UMEM_PROTOCOL_CHECK_EN
    logic              err;
`endif

    always #5 clk = ~clk;

    unified_mem_resp #(
        .ADDR_W     (ADDR_W),
        .LINE_W     (LINE_W),
        .DEPTH_LOG2 (12),
        .LATENCY    (LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .re    (re),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .rdy   (rdy),
        .busy  (busy)
`ifdef UMEM_PROTOCOL_CHECK_EN
        ,
        .err   (err)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [LINE_W-1:0] model [int];
    logic [LINE_W-1:0] rdata_exp = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Quiet cycles: nothing pending, outputs must stay idle.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_rdy", 64'(rdy), 64'd0);
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_rdata", rdata, rdata_exp);
        end
    endtask

    // Issue one request at the current negedge. extra=1 when issued during the
    // rdy cycle (ignored there, captured one cycle later). Returns at the rdy
    // negedge, or one cycle later when hold=1 keeps the strobe through rdy.
    task automatic run_op(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                          input logic [LINE_W-1:0] d, input int extra,
                          input bit hold, input bit perturb);
        int  k;
        bit  got;
        int  idx;
        idx   = int'(a[11:0]);
        re    = r;
        we    = w;
        addr  = a;
        wdata = d;
        if (w)      model[idx] = d;
        else if (r) rdata_exp = model[idx];
        k   = 0;
        got = 1'b0;
        while (!got && k < 50) begin
            @(negedge clk);
            k++;
            if (k <= extra) begin
                check("gap_rdy", 64'(rdy), 64'd0);
                check("gap_busy", 64'(busy), 64'd0);
            end
            if (rdy) got = 1'b1;
            else if (perturb && k > extra) begin
                re    = 1'($urandom);
                we    = 1'($urandom);
                addr  = ADDR_W'($urandom);
                wdata = {$urandom, $urandom};
            end
        end
        check("latency", 64'(k), 64'(LAT + 1 + extra));
        check("rdy_busy", 64'(busy), 64'd1);
        check("rdata", rdata, rdata_exp);
        if (hold) begin
            re    = r;
            we    = w;
            addr  = a;
            @(negedge clk);
            check("no_recapture_busy", 64'(busy), 64'd0);
            check("single_pulse", 64'(rdy), 64'd0);
        end
        re = 1'b0;
        we = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int pool [6];
        bit prev_hold;

        repeat (2) @(negedge clk);
        check("rst_rdy", 64'(rdy), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rdata", rdata, 64'd0);
        rst_n = 1'b1;
        idle(10);

        run_op(1'b0, 1'b1, 14'h005, 64'h1111_2222_3333_4444, 0, 1'b0, 1'b0);
        idle(1);
        run_op(1'b1, 1'b0, 14'h005, 64'h0, 0, 1'b1, 1'b0);
        idle(1);

        run_op(1'b0, 1'b1, 14'h030, 64'h3030_3030_0303_0303, 0, 1'b0, 1'b0);
        idle(1);
        run_op(1'b0, 1'b1, 14'h020, 64'h2020_0000_2020_FFFF, 0, 1'b0, 1'b0);
        idle(1);

        // Eviction then fill, fill raised in the rdy cycle of the eviction.
        run_op(1'b0, 1'b1, 14'h010, 64'h0101_5A5A_A5A5_1010, 0, 1'b0, 1'b0);
        run_op(1'b1, 1'b0, 14'h020, 64'h0, 1, 1'b0, 1'b0);
        idle(1);
        run_op(1'b1, 1'b0, 14'h010, 64'h0, 0, 1'b0, 1'b0);
        idle(1);

        // Both strobes: write wins, rdata keeps the previous read.
        run_op(1'b1, 1'b1, 14'h007, 64'hAAAA_AAAA_AAAA_AAAA, 0, 1'b0, 1'b0);
        idle(1);
`ifdef UMEM_PROTOCOL_CHECK_EN
        check("err_sticky", 64'(err), 64'd1);
`endif
        run_op(1'b1, 1'b0, 14'h007, 64'h0, 0, 1'b0, 1'b0);
        idle(1);

        // Reset during the wait of a write: nothing committed, no rdy.
        we    = 1'b1;
        addr  = 14'h030;
        wdata = 64'hDEAD_BEEF_DEAD_BEEF;
        repeat (2) @(negedge clk);
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        we    = 1'b0;
        rdata_exp = '0;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_rdata", rdata, 64'd0);
        rst_n = 1'b1;
        idle(6);
        run_op(1'b1, 1'b0, 14'h030, 64'h0, 0, 1'b0, 1'b0);
        idle(1);

        // Random traffic over a small pool of lines, upper address bits alias.
        foreach (pool[i]) pool[i] = int'($urandom_range(0, 4095));
        prev_hold = 1'b1;
        for (int n = 0; n < 60; n++) begin
            int               sel;
            int               idx;
            logic             r, w;
            bit               chain, hold;
            logic [ADDR_W-1:0] a;
            sel = int'($urandom % 4);
            idx = pool[$urandom % 6];
            a   = {2'($urandom), 12'(idx)};
            r   = (sel != 1);
            w   = (sel == 1) || (sel == 2);
            if (!w && !model.exists(idx)) w = 1'b1;
            chain = !prev_hold && ($urandom % 3 == 0);
            hold  = ($urandom % 4 == 0);
            if (!prev_hold && !chain) idle(1 + int'($urandom % 2));
            run_op(r, w, a, {$urandom, $urandom}, chain ? 1 : 0, hold, 1'($urandom));
            prev_hold = hold;
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
